// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with valid/ready input and a one-word holding buffer
module uart_tx_cfg #(
  parameter int BAUD_CYCLES = 5,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_txp,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);
  localparam int BW = $clog2(BAUD_CYCLES);
  if (BAUD_CYCLES < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter value");
  end
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, buf_q, buf_d;
  logic par_q, par_d, buf_full_q, buf_full_d, txp_q, txp_d, busy_q, busy_d, done_q, done_d;
  logic bit_end, accept, load;
  assign accept     = i_tx_valid && !buf_full_q;
  assign bit_end    = baud_q == BW'(BAUD_CYCLES - 1);
  assign o_tx_ready = !buf_full_q;
  assign o_txp      = txp_q;
  assign o_tx_busy  = busy_q;
  assign o_tx_done  = done_q;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    done_d  = 1'b0;
    baud_d  = (state_q == ST_IDLE || bit_end) ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE:   load = buf_full_q;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = (bit_q == 4'(DATA_BITS - 1)) ? 4'd0 : bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:
        if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d   = 4'd0;
            done_d  = 1'b1;
            load    = buf_full_q;
            state_d = ST_IDLE;
          end
        end
      default:   state_d = ST_IDLE;
    endcase
    // a buffered word starts its frame on the same edge the previous one ends
    if (load) begin
      shift_d = buf_q;
      par_d   = ^buf_q ^ (PARITY == 1);
      state_d = ST_START;
    end
    buf_full_d = accept || (buf_full_q && !load);
    buf_d      = accept ? i_tx_data : buf_q;
    txp_d      = state_d == ST_START  ? 1'b0 :
                 state_d == ST_DATA   ? shift_d[0] :
                 state_d == ST_PARITY ? par_d : 1'b1;
    busy_d     = state_d != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      par_q      <= 1'b0;
      buf_full_q <= 1'b0;
      txp_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      par_q      <= par_d;
      buf_full_q <= buf_full_d;
      txp_q      <= txp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed checks of frame shape, timing, back-to-back flow and reset abort
module tb_uart_tx_cfg;
  localparam int B = 5;
  logic clk, rst_n;
  logic [7:0] data;
  logic vld [4];
  logic rdy [4];
  logic txp [4];
  logic busy [4];
  logic done [4];
  logic smp_txp [0:255];
  logic smp_done [0:255];
  logic smp_busy [0:255];
  logic smp_rdy [0:255];
  int n_checks = 0;
  int n_fail = 0;

  uart_tx_cfg d0 (.clk(clk), .rst_n(rst_n), .i_tx_data(data), .i_tx_valid(vld[0]),
    .o_tx_ready(rdy[0]), .o_txp(txp[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
  uart_tx_cfg #(.PARITY(2)) d1 (.clk(clk), .rst_n(rst_n), .i_tx_data(data), .i_tx_valid(vld[1]),
    .o_tx_ready(rdy[1]), .o_txp(txp[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
  uart_tx_cfg #(.PARITY(1)) d2 (.clk(clk), .rst_n(rst_n), .i_tx_data(data), .i_tx_valid(vld[2]),
    .o_tx_ready(rdy[2]), .o_txp(txp[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) d3 (.clk(clk), .rst_n(rst_n),
    .i_tx_data(data[6:0]), .i_tx_valid(vld[3]), .o_tx_ready(rdy[3]), .o_txp(txp[3]),
    .o_tx_busy(busy[3]), .o_tx_done(done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // index c holds the value seen c edges after the edge that starts the frame
  task automatic capture(input int k, input int s, input int n);
    for (int c = s; c < s + n; c++) begin
      @(negedge clk);
      smp_txp[c] = txp[k];
      smp_done[c] = done[k];
      smp_busy[c] = busy[k];
      smp_rdy[c] = rdy[k];
      if (c > s && smp_rdy[c-1]) vld[k] = 1'b0;
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic hold);
    data = d;
    vld[k] = 1'b1;
    @(posedge clk); #1;
    if (!hold) vld[k] = 1'b0;
    check($sformatf("acc_rdy%0d", k), 32'(rdy[k]), 0);
    check($sformatf("prefall%0d", k), 32'(txp[k]), 1);
    @(posedge clk); #1;
    check($sformatf("fall%0d", k), 32'(txp[k]), 0);
    check($sformatf("rdy_back%0d", k), 32'(rdy[k]), 1);
  endtask

  function automatic logic [31:0] frame(input int base, input int nb);
    logic [31:0] v = '0;
    for (int i = 0; i < nb; i++) v[i] = smp_txp[base + i*B + 2];
    return v;
  endfunction

  function automatic int unstable(input int base, input int nb);
    int u = 0;
    for (int j = base; j < base + nb*B; j++)
      if (smp_txp[j] !== smp_txp[base + ((j - base) / B) * B + 2]) u++;
    return u;
  endfunction

  function automatic int cnt_done(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (smp_done[j] === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_zero(input int lo, input int hi, input logic use_busy);
    int n = 0;
    for (int j = lo; j <= hi; j++) if ((use_busy ? smp_busy[j] : smp_txp[j]) !== 1'b1) n++;
    return n;
  endfunction

  initial begin
    rst_n = 1'b0;
    data = 8'h00;
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txp", 32'(txp[0]), 1);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_rdy", 32'(rdy[0]), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // 8N1, 0x55
    send(0, 8'h55, 1'b0);
    capture(0, 0, 55);
    check("t1_bits", frame(0, 10), 32'({1'b1, 8'h55, 1'b0}));
    check("t1_hold", unstable(0, 10), 0);
    check("t1_done_at50", 32'(smp_done[50]), 1);
    check("t1_done_cnt", cnt_done(0, 54), 1);
    check("t1_busy49", 32'(smp_busy[49]), 1);
    check("t1_busy50", 32'(smp_busy[50]), 0);
    // even parity, 0xAA has four ones
    send(1, 8'hAA, 1'b0);
    capture(1, 0, 60);
    check("t2e_bits", frame(0, 11), 32'({1'b1, 1'b0, 8'hAA, 1'b0}));
    check("t2e_done_at55", 32'(smp_done[55]), 1);
    check("t2e_done_cnt", cnt_done(0, 59), 1);
    check("t2e_idle_high", cnt_zero(55, 59, 1'b0), 0);
    send(2, 8'hAA, 1'b0);
    capture(2, 0, 60);
    check("t2o_bits", frame(0, 11), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
    check("t2o_done_at55", 32'(smp_done[55]), 1);
    check("t2o_done_cnt", cnt_done(0, 59), 1);
    // 7O2, 7'h41
    send(3, 8'h41, 1'b0);
    capture(3, 0, 60);
    check("t4_bits", frame(0, 11), 32'({2'b11, 1'b1, 7'h41, 1'b0}));
    check("t4_hold", unstable(0, 11), 0);
    check("t4_done_at55", 32'(smp_done[55]), 1);
    check("t4_done_cnt", cnt_done(0, 59), 1);
    // back-to-back 0x12 then 0x34
    send(0, 8'h12, 1'b1);
    data = 8'h34;
    @(posedge clk); #1;
    check("t3_acc2", 32'(rdy[0]), 0);
    vld[0] = 1'b0;
    capture(0, 1, 110);
    check("t3_f1", frame(0, 10), 32'({1'b1, 8'h12, 1'b0}));
    check("t3_f2", frame(50, 10), 32'({1'b1, 8'h34, 1'b0}));
    check("t3_nogap", 32'(smp_txp[50]), 0);
    check("t3_done50", 32'(smp_done[50]), 1);
    check("t3_done100", 32'(smp_done[100]), 1);
    check("t3_done_cnt", cnt_done(1, 110), 2);
    check("t3_busy", cnt_zero(1, 99, 1'b1), 0);
    // buffer full while data toggles: 0xA5 in flight, 0x01 buffered, 0xFE waits
    send(0, 8'hA5, 1'b1);
    data = 8'h01;
    @(posedge clk); #1;
    check("t6_acc01", 32'(rdy[0]), 0);
    data = 8'hFE;
    capture(0, 1, 160);
    check("t6_rdy49", 32'(smp_rdy[49]), 0);
    check("t6_rdy50", 32'(smp_rdy[50]), 1);
    check("t6_rdy51", 32'(smp_rdy[51]), 0);
    check("t6_f1", frame(0, 10), 32'({1'b1, 8'hA5, 1'b0}));
    check("t6_f2", frame(50, 10), 32'({1'b1, 8'h01, 1'b0}));
    check("t6_f3", frame(100, 10), 32'({1'b1, 8'hFE, 1'b0}));
    check("t6_done_cnt", cnt_done(1, 160), 3);
    vld[0] = 1'b0;
    // reset during data bit 3 of 0xFF with 0x00 buffered
    send(0, 8'hFF, 1'b1);
    data = 8'h00;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    check("t5_acc2", 32'(rdy[0]), 0);
    repeat (20) @(negedge clk);
    check("t5_bit3", 32'(txp[0]), 1);
    check("t5_busy_pre", 32'(busy[0]), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_txp", 32'(txp[0]), 1);
    check("t5_busy", 32'(busy[0]), 0);
    check("t5_rdy", 32'(rdy[0]), 1);
    check("t5_done", 32'(done[0]), 0);
    rst_n = 1'b1;
    capture(0, 0, 70);
    check("t5_no_frame", cnt_zero(0, 69, 1'b0), 0);
    check("t5_no_done", cnt_done(0, 69), 0);
    check("t5_idle", 32'(70 - cnt_zero(0, 69, 1'b1)), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
